alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//   Sequencer that drives an ALU. It takes one operation at a time over a valid/ready
//   input handshake and reads its operands from an 8-entry register file.
//   It presents registered operands and a 4-bit select code to the ALU, waits for the
//   programmed settle time, then captures the result. The result is written back to
//   the register file and offered downstream over a valid/ready output handshake.
//   Sits between the instruction front end and the ALU datapath.
// PARAMETERS
//   WIDTH        8   datapath width; ALU operands, register file entries, immediate
//   EXEC_CYC     1   cycles ALU inputs are held before capture, ops other than mul/div (>=1)
//   EXEC_CYC_MD  4   cycles ALU inputs are held before capture, ops mul/div (>=1)
// PORTS
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   in_valid    in   1      operation offered
//   in_ready    out  1      block can accept an operation (high only in IDLE)
//   in_op       in   4      ALU select code, see BEHAVIOUR
//   in_rd       in   3      destination register
//   in_rs       in   3      source register A
//   in_rt       in   3      source register B (unused when in_use_imm=1)
//   in_use_imm  in   1      B operand = in_imm instead of reg[in_rt]
//   in_imm      in   WIDTH  immediate value
//   alu_a       out  WIDTH  ALU operand A, registered
//   alu_b       out  WIDTH  ALU operand B, registered
//   alu_sel     out  4      ALU select, registered
//   alu_res     in   WIDTH  ALU result, combinational from alu_a/alu_b/alu_sel
//   out_valid   out  1      result available
//   out_ready   in   1      downstream accepts result
//   out_data    out  WIDTH  captured result
//   out_rd      out  3      destination register of out_data
//   busy        out  1      state != IDLE
//   dbg_addr    in   3      register file debug read address
//   dbg_data    out  WIDTH  combinational reg[dbg_addr]; 0 when dbg_addr=0
// BEHAVIOUR
//   Select codes (in_op is passed to alu_sel unmodified):
//     0 ADD   1 SUB   2 MUL   3 DIV   4 AND   5 OR    6 XOR   7 NOT_A
//     8 PASS_A  9 PASS_B  10 SLL  11 SRL  12 SRA  13 INC  14 DEC  15 HAM
//   Reset (rst_n low, asynchronous):
//     state=IDLE; all register file entries=0.
//     alu_a, alu_b, alu_sel, out_data, out_rd, out_valid, busy = 0; in_ready=1 after release.
//   Register 0 reads as 0 and ignores writes. Operands are read from the register file
//   at the accepting edge.
//   FSM:
//     IDLE: in_ready=1. On in_valid&&in_ready:
//       - latch alu_a=reg[in_rs], alu_b=in_use_imm?in_imm:reg[in_rt], alu_sel=in_op;
//       - latch rd; load cnt=(op==2||op==3)?EXEC_CYC_MD-1:EXEC_CYC-1; go to EXEC.
//     EXEC: alu_* held stable; cnt decrements each cycle. When cnt==0:
//       - out_data<=alu_res, out_rd<=rd, reg[rd]<=alu_res (skipped if rd==0);
//       - out_valid<=1; go to WB.
//     WB: out_valid=1; out_data and out_rd are held stable. On out_ready go to IDLE
//       with out_valid<=0.
//   Latency: out_valid rises exactly N edges after the accepting edge (N=EXEC_CYC, or
//     EXEC_CYC_MD for mul/div).
//   Peak throughput: one op per N+2 cycles, with out_ready held high.
//   in_valid outside IDLE is ignored (in_ready=0). No operation is queued.
//   Writeback happens once, on the EXEC->WB edge. Downstream stall never re-writes.
//   Arithmetic (overflow wrap, div-by-zero, shift amount) is defined by the ALU.
//     This block passes results through unchanged. alu_a/alu_b/alu_sel keep their
//     last values in IDLE and WB.
//   Reset mid-EXEC or mid-WB aborts the op: no writeback, out_valid=0, regs cleared.
// STRUCTURE
//   Shared package alu_pkg: the 16 select-code localparams (ALU_ADD..ALU_HAM) and the
//     state enum (IDLE, EXEC, WB); the ALU itself uses the same constants.
//   One sub-module: alu_regfile (8 x WIDTH, 1 write port, 3 combinational read ports
//     for rs, rt and debug, r0 hardwired 0).
// TESTING (WIDTH=8, EXEC_CYC=1, EXEC_CYC_MD=4, ALU attached)
//   1. Pulse rst_n low -> all outputs 0, in_ready=1, dbg_data=0 for every address.
//   2. op9 rd1 imm 0x05 use_imm, then op0 rd2 rs1 imm 0x03 ->
//        out_data=0x05 then 0x08; out_rd=2; out_valid 1 edge after accept.
//   3. op0 rd3 rs1 imm 0xFF -> out_data=0x04 (wrap).
//      op2 rd4 rs1 imm 0x03 -> out_data=0x0F, out_valid 4 edges after accept.
//   4. out_ready low 5 cycles in WB -> out_valid, out_data, in_ready=0 stable.
//      in_valid pulses are ignored. reg[rd] is written exactly once.
//   5. op9 rd0 imm 0xAA -> out_data=0xAA, dbg_addr=0 gives dbg_data=0x00.
//   6. rst_n low during EXEC of a mul -> out_valid never rises, dbg reads 0 for all regs,
//        and the next op completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU select codes, issue FSM states and small helpers.
package alu_pkg;

    localparam int unsigned SEL_W    = 4;
    localparam int unsigned REG_AW   = 3;
    localparam int unsigned NUM_REGS = 8;

    localparam logic [SEL_W-1:0] ALU_ADD    = 4'd0;
    localparam logic [SEL_W-1:0] ALU_SUB    = 4'd1;
    localparam logic [SEL_W-1:0] ALU_MUL    = 4'd2;
    localparam logic [SEL_W-1:0] ALU_DIV    = 4'd3;
    localparam logic [SEL_W-1:0] ALU_AND    = 4'd4;
    localparam logic [SEL_W-1:0] ALU_OR     = 4'd5;
    localparam logic [SEL_W-1:0] ALU_XOR    = 4'd6;
    localparam logic [SEL_W-1:0] ALU_NOT_A  = 4'd7;
    localparam logic [SEL_W-1:0] ALU_PASS_A = 4'd8;
    localparam logic [SEL_W-1:0] ALU_PASS_B = 4'd9;
    localparam logic [SEL_W-1:0] ALU_SLL    = 4'd10;
    localparam logic [SEL_W-1:0] ALU_SRL    = 4'd11;
    localparam logic [SEL_W-1:0] ALU_SRA    = 4'd12;
    localparam logic [SEL_W-1:0] ALU_INC    = 4'd13;
    localparam logic [SEL_W-1:0] ALU_DEC    = 4'd14;
    localparam logic [SEL_W-1:0] ALU_HAM    = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Multiply and divide use the long settle time.
    function automatic logic is_muldiv(input logic [SEL_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8-entry register file: one write port, rs/rt/debug combinational reads, r0 reads 0.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [2:0]        rs_addr,
    output logic [WIDTH-1:0]  rs_data,
    input  logic [2:0]        rt_addr,
    output logic [WIDTH-1:0]  rt_data,
    input  logic [2:0]        dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    logic [WIDTH-1:0] mem [NUM_REGS];

    // Storage; writes to r0 are dropped so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != 3'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports with r0 forced to zero.
    always_comb begin
        rs_data  = (rs_addr  == 3'd0) ? '0 : mem[rs_addr];
        rt_data  = (rt_addr  == 3'd0) ? '0 : mem[rt_addr];
        dbg_data = (dbg_addr == 3'd0) ? '0 : mem[dbg_addr];
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU sequencer: accept op, hold registered operands for the settle
// time, capture the result, write it back and offer it downstream.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EXEC_CYC    = 1,
    parameter int unsigned EXEC_CYC_MD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic              in_use_imm,
    input  logic [WIDTH-1:0]  in_imm,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [3:0]        alu_sel,
    input  logic [WIDTH-1:0]  alu_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [2:0]        out_rd,
    output logic              busy,
    input  logic [2:0]        dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int unsigned CNT_MAX = (EXEC_CYC_MD > EXEC_CYC) ? EXEC_CYC_MD : EXEC_CYC;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LD    = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LD_MD = CNT_W'(EXEC_CYC_MD - 1);

    state_t           state,      state_nxt;
    logic [WIDTH-1:0] alu_a_nxt,  alu_b_nxt;
    logic [3:0]       alu_sel_nxt;
    logic [2:0]       rd,         rd_nxt;
    logic [CNT_W-1:0] cnt,        cnt_nxt;
    logic [WIDTH-1:0] out_data_nxt;
    logic [2:0]       out_rd_nxt;
    logic             out_valid_nxt;
    logic             wb_we;
    logic [WIDTH-1:0] rs_data, rt_data;

    alu_regfile #(
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wb_we),
        .waddr    (rd),
        .wdata    (alu_res),
        .rs_addr  (in_rs),
        .rs_data  (rs_data),
        .rt_addr  (in_rt),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rd        <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_rd    <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            alu_a     <= alu_a_nxt;
            alu_b     <= alu_b_nxt;
            alu_sel   <= alu_sel_nxt;
            rd        <= rd_nxt;
            cnt       <= cnt_nxt;
            out_data  <= out_data_nxt;
            out_rd    <= out_rd_nxt;
            out_valid <= out_valid_nxt;
        end
    end

    // Next-state, operand latch, settle countdown and single writeback.
    always_comb begin
        state_nxt     = state;
        alu_a_nxt     = alu_a;
        alu_b_nxt     = alu_b;
        alu_sel_nxt   = alu_sel;
        rd_nxt        = rd;
        cnt_nxt       = cnt;
        out_data_nxt  = out_data;
        out_rd_nxt    = out_rd;
        out_valid_nxt = out_valid;
        wb_we         = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    alu_a_nxt   = rs_data;
                    alu_b_nxt   = in_use_imm ? in_imm : rt_data;
                    alu_sel_nxt = in_op;
                    rd_nxt      = in_rd;
                    cnt_nxt     = is_muldiv(in_op) ? CNT_LD_MD : CNT_LD;
                    state_nxt   = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    out_data_nxt  = alu_res;
                    out_rd_nxt    = rd;
                    out_valid_nxt = 1'b1;
                    wb_we         = 1'b1;
                    state_nxt     = WB;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WB: begin
                if (out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake status decoded straight from the state register.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule
